// File: rtl/regfile_writeback_if.sv
// Upstream-facing and register-file-facing signals of regfile_writeback.
// Forwarding lookup signals exist only when WB_BYPASS_EN is defined.
interface regfile_writeback_if;
   logic        alu_valid;
   logic [4:0]  alu_dest;
   logic [31:0] alu_result;
   logic        mem_valid;
   logic [4:0]  mem_dest;
   logic [31:0] mem_data;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic [1:0]  mem_offset;
   logic        in_ready;
   logic [4:0]  rd_index;
   logic [31:0] rd_data;
   logic        write_enable;
   logic        wb_busy;
   logic        overflow;
   logic        misaligned;
`ifdef WB_BYPASS_EN
   logic [4:0]  fwd_rs_index;
   logic [4:0]  fwd_rt_index;
   logic        fwd_rs_hit;
   logic [31:0] fwd_rs_data;
   logic        fwd_rt_hit;
   logic [31:0] fwd_rt_data;

   modport master (
      output alu_valid, alu_dest, alu_result,
      output mem_valid, mem_dest, mem_data, mem_size, mem_signed, mem_offset,
      output fwd_rs_index, fwd_rt_index,
      input  in_ready, rd_index, rd_data, write_enable, wb_busy, overflow, misaligned,
      input  fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
   );
   modport slave (
      input  alu_valid, alu_dest, alu_result,
      input  mem_valid, mem_dest, mem_data, mem_size, mem_signed, mem_offset,
      input  fwd_rs_index, fwd_rt_index,
      output in_ready, rd_index, rd_data, write_enable, wb_busy, overflow, misaligned,
      output fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
   );
`else
   modport master (
      output alu_valid, alu_dest, alu_result,
      output mem_valid, mem_dest, mem_data, mem_size, mem_signed, mem_offset,
      input  in_ready, rd_index, rd_data, write_enable, wb_busy, overflow, misaligned
   );
   modport slave (
      input  alu_valid, alu_dest, alu_result,
      input  mem_valid, mem_dest, mem_data, mem_size, mem_signed, mem_offset,
      output in_ready, rd_index, rd_data, write_enable, wb_busy, overflow, misaligned
   );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// Serialises ALU and load results onto the register file's single write port.
// Define WB_BYPASS_EN to add the combinational forwarding lookup over pending writes.
module regfile_writeback #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   regfile_writeback_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } entry_t;

   entry_t        w_slot [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic [4:0]    r_rd_index;
   logic [31:0]   r_rd_data;
   logic          r_we;
   logic          r_overflow;
   logic          r_misaligned;

   logic          w_in_ready;
   logic          w_alu_push;
   logic          w_mem_take;
   logic          w_mem_push;
   logic          w_pop;
   logic [AW-1:0] w_mem_slot;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic          w_load_err;

   // No credit is taken for the same-cycle pop, so two pushes always fit.
   assign w_in_ready = (r_count <= (AW+1)'(DEPTH - 2));
   assign w_pop      = (r_count != '0);

   // Big-endian lanes: offset 0 is the most significant byte.
   always_comb begin
      w_byte     = 8'h00;
      w_half     = bus.mem_offset[1] ? bus.mem_data[15:0] : bus.mem_data[31:16];
      w_load     = bus.mem_data;
      w_load_err = 1'b0;
      case (bus.mem_offset)
         2'd0:    w_byte = bus.mem_data[31:24];
         2'd1:    w_byte = bus.mem_data[23:16];
         2'd2:    w_byte = bus.mem_data[15:8];
         default: w_byte = bus.mem_data[7:0];
      endcase
      case (bus.mem_size)
         2'd0: w_load = bus.mem_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
         2'd1: begin
            w_load     = bus.mem_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            w_load_err = bus.mem_offset[0];
         end
         2'd2: w_load_err = (bus.mem_offset != 2'd0);
         default: w_load_err = 1'b1;
      endcase
   end

   assign w_alu_push = bus.alu_valid & w_in_ready & (bus.alu_dest != 5'd0);
   assign w_mem_take = bus.mem_valid & w_in_ready;
   assign w_mem_push = w_mem_take & (bus.mem_dest != 5'd0) & ~w_load_err;
   assign w_mem_slot = r_tail + AW'(w_alu_push);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t r_ent;
         always_ff @(posedge clk) begin
            if (w_alu_push && r_tail == AW'(gi)) begin
               r_ent <= '{idx: bus.alu_dest, data: bus.alu_result};
            end else if (w_mem_push && w_mem_slot == AW'(gi)) begin
               r_ent <= '{idx: bus.mem_dest, data: w_load};
            end
         end
         assign w_slot[gi] = r_ent;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_rd_index   <= 5'd0;
         r_rd_data    <= 32'h0;
         r_we         <= 1'b0;
         r_overflow   <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_tail  <= r_tail + AW'(w_alu_push) + AW'(w_mem_push);
         r_head  <= r_head + AW'(w_pop);
         r_count <= r_count + (AW+1)'(w_alu_push) + (AW+1)'(w_mem_push) - (AW+1)'(w_pop);
         r_we    <= w_pop;
         if (w_pop) begin
            r_rd_index <= w_slot[r_head].idx;
            r_rd_data  <= w_slot[r_head].data;
         end
         if ((bus.alu_valid | bus.mem_valid) & ~w_in_ready) r_overflow <= 1'b1;
         if (w_mem_take & w_load_err) r_misaligned <= 1'b1;
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.rd_index     = r_rd_index;
   assign bus.rd_data      = r_rd_data;
   assign bus.write_enable = r_we;
   assign bus.wb_busy      = (r_count != '0) | r_we;
   assign bus.overflow     = r_overflow;
   assign bus.misaligned   = r_misaligned;

`ifdef WB_BYPASS_EN
   logic [AW-1:0] w_scan;

   // Scan oldest to youngest so the last match wins; the output register is oldest.
   always_comb begin
      bus.fwd_rs_hit  = 1'b0;
      bus.fwd_rs_data = 32'h0;
      bus.fwd_rt_hit  = 1'b0;
      bus.fwd_rt_data = 32'h0;
      w_scan          = '0;
      if (r_we && r_rd_index == bus.fwd_rs_index) begin
         bus.fwd_rs_hit  = 1'b1;
         bus.fwd_rs_data = r_rd_data;
      end
      if (r_we && r_rd_index == bus.fwd_rt_index) begin
         bus.fwd_rt_hit  = 1'b1;
         bus.fwd_rt_data = r_rd_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         w_scan = r_head + AW'(k);
         if ((AW+1)'(k) < r_count) begin
            if (w_slot[w_scan].idx == bus.fwd_rs_index) begin
               bus.fwd_rs_hit  = 1'b1;
               bus.fwd_rs_data = w_slot[w_scan].data;
            end
            if (w_slot[w_scan].idx == bus.fwd_rt_index) begin
               bus.fwd_rt_hit  = 1'b1;
               bus.fwd_rt_data = w_slot[w_scan].data;
            end
         end
      end
      if (bus.fwd_rs_index == 5'd0) begin
         bus.fwd_rs_hit  = 1'b0;
         bus.fwd_rs_data = 32'h0;
      end
      if (bus.fwd_rt_index == 5'd0) begin
         bus.fwd_rt_hit  = 1'b0;
         bus.fwd_rt_data = 32'h0;
      end
   end
`endif
endmodule
